// File: rtl/toggle_edge_counter.sv
// toggle_edge_counter: synchronises the toggling output of the T flip-flop
// stage, emits one-cycle rise/fall pulses, counts edges over a fixed window
// of clk cycles and offers the saturating count through a valid/ready handshake.
module toggle_edge_counter #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_in,
    input  logic             start,
    output logic             busy,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             overflow,
    output logic             cnt_valid,
    input  logic             cnt_ready
);

    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             s3;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;

    // Two-flop synchroniser, one history flop and registered edge pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            s1         <= t_in;
            s2         <= s1;
            s3         <= s2;
            rise_pulse <= s2 & ~s3;
            fall_pulse <= ~s2 & s3;
        end
    end

    // State, window counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            win_cnt  <= win_nxt;
            edge_cnt <= cnt_nxt;
            overflow <= ovf_nxt;
        end
    end

    // Next-state, window/count update and handshake outputs.
    always_comb begin
        state_nxt = state;
        win_nxt   = win_cnt;
        cnt_nxt   = edge_cnt;
        ovf_nxt   = overflow;
        busy      = 1'b0;
        cnt_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MEASURE;
                    win_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            MEASURE: begin
                busy    = 1'b1;
                win_nxt = win_cnt + 1'b1;
                if (rise_pulse | fall_pulse) begin
                    if (edge_cnt == CNT_MAX) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        cnt_nxt = edge_cnt + 1'b1;
                    end
                end
                if (win_cnt == WIN_LAST) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                busy      = 1'b1;
                cnt_valid = 1'b1;
                if (cnt_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_toggle_edge_counter.sv
// Bench for toggle_edge_counter: a default instance (CNT_W=8, WINDOW=16) and a
// saturating instance (CNT_W=4, WINDOW=20) share one directed stimulus stream.
// A behavioural model predicts every output each cycle; literal checks pin it.
module tb_toggle_edge_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       t_in = 1'b0;
    logic       start = 1'b1;
    logic       cnt_ready = 1'b0;

    logic       a_busy, a_rise, a_fall, a_ov, a_valid;
    logic [7:0] a_cnt;
    logic       b_busy, b_rise, b_fall, b_ov, b_valid;
    logic [3:0] b_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit tog_en = 1'b0;

    always #5 clk = ~clk;

    toggle_edge_counter #(.CNT_W(8), .WINDOW(16)) u_dut (
        .clk(clk), .rst(rst), .t_in(t_in), .start(start),
        .busy(a_busy), .rise_pulse(a_rise), .fall_pulse(a_fall),
        .edge_cnt(a_cnt), .overflow(a_ov), .cnt_valid(a_valid),
        .cnt_ready(cnt_ready)
    );

    toggle_edge_counter #(.CNT_W(4), .WINDOW(20)) u_sat (
        .clk(clk), .rst(rst), .t_in(t_in), .start(start),
        .busy(b_busy), .rise_pulse(b_rise), .fall_pulse(b_fall),
        .edge_cnt(b_cnt), .overflow(b_ov), .cnt_valid(b_valid),
        .cnt_ready(cnt_ready)
    );

    // ---------------- behavioural model ----------------
    // Edge k: rst_at[k] says reset was sampled; eff[k] is t_in as seen by a
    // synchroniser that was not reset. A pulse appears after edge k when the
    // input seen two edges ago differs from the one three edges ago, and no
    // reset landed in the last three edges.
    bit          rst_at [0:8191];
    bit          eff    [0:8191];
    int unsigned k = 3;
    bit          m_rise = 1'b0;
    bit          m_fall = 1'b0;
    int          win_len [2] = '{16, 20};
    int          cnt_max [2] = '{255, 15};
    int          m_left  [2] = '{0, 0};
    bit          m_hold  [2] = '{1'b0, 1'b0};
    int          m_raw   [2] = '{0, 0};

    function automatic int m_cnt(input int i);
        return (m_raw[i] > cnt_max[i]) ? cnt_max[i] : m_raw[i];
    endfunction

    initial begin
        bit pulse_now;
        for (int i = 0; i < 3; i++) begin
            rst_at[i] = 1'b1;
        end
        forever begin
            @(posedge clk);
            pulse_now = m_rise | m_fall;
            rst_at[k] = !rst;
            eff[k]    = rst ? t_in : 1'b0;
            m_rise = !(rst_at[k] | rst_at[k-1] | rst_at[k-2]) && eff[k-2] && !eff[k-3];
            m_fall = !(rst_at[k] | rst_at[k-1] | rst_at[k-2]) && !eff[k-2] && eff[k-3];
            for (int i = 0; i < 2; i++) begin
                if (!rst) begin
                    m_left[i] = 0;
                    m_hold[i] = 1'b0;
                    m_raw[i]  = 0;
                end else if (m_hold[i]) begin
                    if (cnt_ready) m_hold[i] = 1'b0;
                end else if (m_left[i] > 0) begin
                    if (pulse_now) m_raw[i]++;
                    m_left[i]--;
                    if (m_left[i] == 0) m_hold[i] = 1'b1;
                end else if (start) begin
                    m_raw[i]  = 0;
                    m_left[i] = win_len[i];
                end
            end
            k++;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("a_busy",  int'(a_busy),  int'(m_left[0] > 0 || m_hold[0]));
                check("a_valid", int'(a_valid), int'(m_hold[0]));
                check("a_cnt",   int'(a_cnt),   m_cnt(0));
                check("a_ov",    int'(a_ov),    int'(m_raw[0] > cnt_max[0]));
                check("a_rise",  int'(a_rise),  int'(m_rise));
                check("a_fall",  int'(a_fall),  int'(m_fall));
                check("b_busy",  int'(b_busy),  int'(m_left[1] > 0 || m_hold[1]));
                check("b_valid", int'(b_valid), int'(m_hold[1]));
                check("b_cnt",   int'(b_cnt),   m_cnt(1));
                check("b_ov",    int'(b_ov),    int'(m_raw[1] > cnt_max[1]));
                check("b_rise",  int'(b_rise),  int'(m_rise));
                check("b_fall",  int'(b_fall),  int'(m_fall));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (tog_en) t_in = ~t_in;
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!(a_valid && b_valid) && n < 60) begin
            tick(1);
            n++;
        end
        check(name, int'(a_valid && b_valid), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic release_result();
        cnt_ready = 1'b1;
        tick(1);
        cnt_ready = 1'b0;
    endtask

    initial begin
        // Reset with start and t_in=0 held for two cycles.
        tick(1);
        chk_en = 1'b1;
        tick(1);
        check("rst_busy",  int'(a_busy),  0);
        check("rst_valid", int'(a_valid), 0);
        check("rst_cnt",   int'(a_cnt),   0);
        check("rst_ov",    int'(a_ov),    0);
        check("rst_rise",  int'(a_rise),  0);
        check("rst_fall",  int'(a_fall),  0);
        rst   = 1'b1;
        start = 1'b0;
        tick(4);
        check("idle_no_start", int'(a_busy), 0);

        // Edge latency: change sampled at edge N, pulse visible N+2..N+3.
        t_in = 1'b1;
        tick(1);
        check("rise_n0", int'(a_rise), 0);
        tick(1);
        check("rise_n1", int'(a_rise), 0);
        tick(1);
        check("rise_n2", int'(a_rise), 1);
        check("rise_n2_nofall", int'(a_fall), 0);
        tick(1);
        check("rise_n3", int'(a_rise), 0);
        tick(4);
        t_in = 1'b0;
        tick(2);
        check("fall_n1", int'(a_fall), 0);
        tick(1);
        check("fall_n2", int'(a_fall), 1);
        tick(1);
        check("fall_n3", int'(a_fall), 0);
        tick(4);

        // Full-rate count; the narrow instance saturates.
        tog_en = 1'b1;
        tick(4);
        pulse_start();
        wait_valid("full_valid");
        check("full_cnt16", int'(a_cnt), 16);
        check("full_ov0",   int'(a_ov),  0);
        check("sat_cnt15",  int'(b_cnt), 15);
        check("sat_ov1",    int'(b_ov),  1);
        release_result();
        check("full_released", int'(a_valid), 0);

        // Quiet input gives zero.
        tog_en = 1'b0;
        t_in   = 1'b0;
        tick(5);
        pulse_start();
        wait_valid("quiet_valid");
        check("quiet_cnt0", int'(a_cnt), 0);
        check("quiet_ov0",  int'(a_ov),  0);
        release_result();

        // Backpressure in HOLD, with start pulsed and ignored.
        tog_en = 1'b1;
        tick(4);
        pulse_start();
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick(1);
            check("bp_cnt",  int'(a_cnt),  16);
            check("bp_busy", int'(a_busy), 1);
        end
        start     = 1'b1;
        cnt_ready = 1'b1;
        tick(1);
        start     = 1'b0;
        cnt_ready = 1'b0;
        check("bp_valid_low", int'(a_valid), 0);
        check("bp_busy_low",  int'(a_busy),  0);
        tick(2);
        check("bp_start_ignored", int'(a_busy), 0);

        // Reset in the middle of a window, then a clean measurement.
        tick(2);
        pulse_start();
        tick(7);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check("mid_rst_busy", int'(a_busy), 0);
        check("mid_rst_cnt",  int'(a_cnt),  0);
        check("mid_rst_rise", int'(a_rise) | int'(a_fall), 0);
        tick(4);
        pulse_start();
        wait_valid("post_rst_valid");
        check("post_rst_cnt16", int'(a_cnt), 16);
        release_result();
        tog_en = 1'b0;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
